alu_mul_seq: RTL

- Multi-cycle sequencer that computes the 16x16 multiply (low 16 bits of the product) by stepping the existing shared 16-bit alu through a shift-add loop.
- Owns the alu while busy; when idle, it grants the alu to the external datapath through a pass-through port.
- Sits beside the register file/datapath and serves MUL instructions that the single-cycle alu cannot execute.

---
 rtl/alu_mul_seq_pkg.sv | 24 ++
 rtl/alu_mul_seq_alu.sv | 31 +++
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-add multiply sequencer and its alu.
package alu_mul_seq_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_INC = 4'd4;
  localparam logic [3:0] ALU_DEC = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_SAR = 4'd8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADD  = 3'd1;
  localparam logic [2:0] ST_SHM  = 3'd2;
  localparam logic [2:0] ST_SHQ  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Shared single-cycle 16-bit alu; shifts move by one bit and ignore operand b.
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  // Operation decode; unused control codes yield zero.
  always_comb begin
    y = 16'h0000;
    case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_XOR: y = a ^ b;
      ALU_AND: y = a & b;
      ALU_INC: y = a + 16'd1;
      ALU_DEC: y = a - 16'd1;
      ALU_SHL: y = {a[WIDTH-2:0], 1'b0};
      ALU_SHR: y = {1'b0, a[WIDTH-1:1]};
      ALU_SAR: y = {a[WIDTH-1], a[WIDTH-1:1]};
      default: y = 16'h0000;
    endcase
  end

  assign zero = (y == 16'h0000);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 multiplier (low half) that borrows the shared alu while busy
// and otherwise hands the alu straight through to the external datapath.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_zero,
  input  logic [WIDTH-1:0] ext_a,
  input  logic [WIDTH-1:0] ext_b,
  input  logic [3:0]       ext_ctrl,
  output logic [WIDTH-1:0] ext_y,
  output logic             ext_grant
);

  localparam bit EE_ON = (EARLY_EXIT != 32'sd0);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             busy_r;
  logic             done_r;
  word_t            m_r;
  word_t            q_r;
  word_t            p_r;
  logic [3:0]       cnt_r;
  word_t            product_r;
  logic             prod_zero_r;
  word_t            alu_a_s;
  word_t            alu_b_s;
  logic [3:0]       alu_ctrl_s;
  word_t            alu_y_s;
  logic             alu_zero_s;

  alu_mul_seq_alu u_alu (
    .a    (alu_a_s),
    .b    (alu_b_s),
    .ctrl (alu_ctrl_s),
    .y    (alu_y_s),
    .zero (alu_zero_s)
  );

  // Alu operand mux: the sequencer owns the alu in its working states only.
  always_comb begin
    alu_a_s    = ext_a;
    alu_b_s    = ext_b;
    alu_ctrl_s = ext_ctrl;
    case (state_r)
      ST_ADD: begin
        alu_a_s    = p_r;
        alu_b_s    = m_r;
        alu_ctrl_s = ALU_ADD;
      end
      ST_SHM: begin
        alu_a_s    = m_r;
        alu_b_s    = 16'h0000;
        alu_ctrl_s = ALU_SHL;
      end
      ST_SHQ: begin
        alu_a_s    = q_r;
        alu_b_s    = 16'h0000;
        alu_ctrl_s = ALU_SHR;
      end
      default: begin
        alu_a_s    = ext_a;
        alu_b_s    = ext_b;
        alu_ctrl_s = ext_ctrl;
      end
    endcase
  end

  // Next-state logic; the shifted multiplier reaching zero ends the loop early.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ADD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ADD: state_nxt_s = ST_SHM;
      ST_SHM: state_nxt_s = ST_SHQ;
      ST_SHQ: begin
        if ((cnt_r == 4'd15) || (EE_ON && alu_zero_s)) state_nxt_s = ST_DONE;
        else                                          state_nxt_s = ST_ADD;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      m_r         <= 16'h0000;
      q_r         <= 16'h0000;
      p_r         <= 16'h0000;
      cnt_r       <= 4'd0;
      product_r   <= 16'h0000;
      prod_zero_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_ADD) || (state_nxt_s == ST_SHM) ||
                 (state_nxt_s == ST_SHQ);
      done_r  <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            m_r   <= op_a;
            q_r   <= op_b;
            p_r   <= 16'h0000;
            cnt_r <= 4'd0;
          end
        end
        ST_ADD: begin
          if (q_r[0]) p_r <= alu_y_s;
        end
        ST_SHM: m_r <= alu_y_s;
        ST_SHQ: begin
          q_r <= alu_y_s;
          if (state_nxt_s == ST_ADD) cnt_r <= cnt_r + 4'd1;
        end
        ST_DONE: begin
          product_r   <= p_r;
          prod_zero_r <= (p_r == 16'h0000);
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign product   = product_r;
  assign prod_zero = prod_zero_r;
  assign ext_y     = alu_y_s;
  assign ext_grant = ~busy_r;

endmodule
